// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_pkg
//  Description : Shared types and constants for the branch-metric sequencer.
//                metric_t    - 2-bit Hamming distance (0..2)
//                seq_state_t - sequencer phase (IDLE, PH0, PH1)
//                PH0_MASK / PH1_MASK - XOR masks applied to the symbol
//                before it is handed to the shared BMC in each phase.
//  Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    typedef logic [1:0] metric_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } seq_state_t;

    // PH0 asks the BMC about codewords 00/11 directly; PH1 flips the low
    // bit so the same 00/11 distances become distances to 01/10.
    localparam metric_t PH0_MASK = 2'b00;
    localparam metric_t PH1_MASK = 2'b01;

endpackage
`default_nettype wire

// File: rtl/sym_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sym_fifo
//  Description : Small synchronous FIFO for received symbol pairs.
//                Ports: clk, rst_n (sync, active-low), push/wr_data,
//                pop/rd_data (first-word fall-through head), full, empty,
//                count (0..DEPTH).
//                Push while full and pop while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bmc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bmc_seq
//  Description : Two-phase sequencer sharing one 00/11 hard-decision BMC
//                across all four rate-1/2 codeword hypotheses.
//                Ports:
//                  clk, rst_n               - clock, sync active-low reset
//                  in_valid/in_ready/rx_pair - symbol input handshake
//                  bmc_rx_pair              - operand to the external BMC
//                  bmc_path_0/bmc_path_1    - BMC distances to 00 / 11
//                  bm_valid/bm_ready        - metric output handshake
//                  bm_00/01/10/11           - per-codeword distances
//                  bm_sof/bm_eof            - frame markers
//  Revision    : 1.0 - initial release
// ============================================================================
module bmc_seq
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] rx_pair,
    output logic [1:0] bmc_rx_pair,
    input  logic [1:0] bmc_path_0,
    input  logic [1:0] bmc_path_1,
    output logic       bm_valid,
    input  logic       bm_ready,
    output logic [1:0] bm_00,
    output logic [1:0] bm_01,
    output logic [1:0] bm_10,
    output logic [1:0] bm_11,
    output logic       bm_sof,
    output logic       bm_eof
);

    localparam int c_cnt_w   = $clog2(FRAME_LEN);
    localparam int c_fifo_aw = $clog2(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0]  c_frame_last = c_cnt_w'(FRAME_LEN - 1);
    localparam logic [c_fifo_aw:0]  c_one_entry  = (c_fifo_aw+1)'(1);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic                w_push;
    logic                w_load;
    logic                w_more;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_fifo_aw:0]  w_fifo_count;
    metric_t             w_head;
    metric_t             w_bmc_rx;
    metric_t             r_tmp_00;
    metric_t             r_tmp_11;
    metric_t             r_bm_00;
    metric_t             r_bm_01;
    metric_t             r_bm_10;
    metric_t             r_bm_11;
    logic                r_bm_valid;
    logic                r_bm_sof;
    logic                r_bm_eof;
    logic [c_cnt_w-1:0]  r_frame_cnt;

    // in_ready is forced low while reset is held, independent of FIFO state.
    assign in_ready = rst_n & ~w_fifo_full;
    assign w_push   = in_valid & in_ready;

    // After popping the head, another entry remains unless the FIFO held
    // exactly one and nothing is arriving this cycle.
    assign w_more   = (w_fifo_count != c_one_entry) | w_push;

    sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data (rx_pair),
        .pop     (w_load),
        .rd_data (w_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_bmc_rx     = 2'b00;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_next = PH0;
                end
            end
            PH0: begin
                w_bmc_rx     = w_head ^ PH0_MASK;
                w_state_next = PH1;
            end
            PH1: begin
                w_bmc_rx = w_head ^ PH1_MASK;
                // Bubble-free: load whenever the output slot is empty or
                // being drained this very cycle; otherwise stall here.
                if (!r_bm_valid || bm_ready) begin
                    w_load       = 1'b1;
                    w_state_next = w_more ? PH0 : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bmc_rx_pair = w_bmc_rx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmp_00    <= '0;
            r_tmp_11    <= '0;
            r_bm_00     <= '0;
            r_bm_01     <= '0;
            r_bm_10     <= '0;
            r_bm_11     <= '0;
            r_bm_valid  <= 1'b0;
            r_bm_sof    <= 1'b0;
            r_bm_eof    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (r_state == PH0) begin
                r_tmp_00 <= bmc_path_0;
                r_tmp_11 <= bmc_path_1;
            end
            if (w_load) begin
                r_bm_00     <= r_tmp_00;
                r_bm_11     <= r_tmp_11;
                // Operand was head^01, so its 00/11 distances are the
                // symbol's distances to 01/10.
                r_bm_01     <= bmc_path_0;
                r_bm_10     <= bmc_path_1;
                r_bm_valid  <= 1'b1;
                r_bm_sof    <= (r_frame_cnt == '0);
                r_bm_eof    <= (r_frame_cnt == c_frame_last);
                r_frame_cnt <= (r_frame_cnt == c_frame_last) ? '0
                                                              : r_frame_cnt + 1'b1;
            end else if (bm_ready) begin
                r_bm_valid <= 1'b0;
            end
        end
    end

    assign bm_valid = r_bm_valid;
    assign bm_00    = r_bm_00;
    assign bm_01    = r_bm_01;
    assign bm_10    = r_bm_10;
    assign bm_11    = r_bm_11;
    assign bm_sof   = r_bm_sof;
    assign bm_eof   = r_bm_eof;

endmodule
`default_nettype wire

// File: tb/tb_bmc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bmc_seq
//  Description : Self-checking bench for bmc_seq. Models the external BMC,
//                keeps a queue of accepted symbols and derives every
//                expected metric from Hamming distance to each codeword.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bmc_seq;

    localparam int FL    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] rx_pair;
    logic [1:0] bmc_rx_pair;
    logic [1:0] bmc_path_0;
    logic [1:0] bmc_path_1;
    logic       bm_valid;
    logic       bm_ready;
    logic [1:0] bm_00;
    logic [1:0] bm_01;
    logic [1:0] bm_10;
    logic [1:0] bm_11;
    logic       bm_sof;
    logic       bm_eof;

    always #5 clk = ~clk;

    // External shared BMC: distance to 00 is the popcount, to 11 its complement.
    assign bmc_path_0 = {1'b0, bmc_rx_pair[0]} + {1'b0, bmc_rx_pair[1]};
    assign bmc_path_1 = 2'd2 - bmc_path_0;

    bmc_seq #(
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rx_pair     (rx_pair),
        .bmc_rx_pair (bmc_rx_pair),
        .bmc_path_0  (bmc_path_0),
        .bmc_path_1  (bmc_path_1),
        .bm_valid    (bm_valid),
        .bm_ready    (bm_ready),
        .bm_00       (bm_00),
        .bm_01       (bm_01),
        .bm_10       (bm_10),
        .bm_11       (bm_11),
        .bm_sof      (bm_sof),
        .bm_eof      (bm_eof)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];
    int         out_idx  = 0;
    int         hs_cnt   = 0;
    int         sof_cnt  = 0;
    int         eof_cnt  = 0;
    logic       prev_valid = 1'b0;
    logic       chk_alt    = 1'b0;
    logic       saw_full   = 1'b0;
    logic       last_push  = 1'b0;

    function automatic int ham(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return int'(x[0]) + int'(x[1]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes before the edge, update the model, then
    // check outputs 1 ns after the edge.
    task automatic cycle();
        logic       pushed, popped, was_reset, s_sof, s_eof;
        logic [1:0] sym;
        logic [1:0] s;
        #1;
        pushed    = in_valid && in_ready;
        popped    = bm_valid && bm_ready;
        was_reset = !rst_n;
        sym       = rx_pair;
        s_sof     = bm_sof;
        s_eof     = bm_eof;
        @(posedge clk);
        #1;
        last_push = pushed && !was_reset;
        if (was_reset) begin
            exp_q.delete();
            out_idx = 0;
            chk("reset_outputs",
                {21'd0, bm_valid, bm_sof, bm_eof, bm_00, bm_01, bm_10, bm_11, bmc_rx_pair}, 32'd0);
        end else begin
            if (popped) begin
                hs_cnt++;
                if (s_sof) sof_cnt++;
                if (s_eof) eof_cnt++;
                out_idx++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (pushed) exp_q.push_back(sym);
            if (bm_valid) begin
                chk("valid_has_symbol", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    s = exp_q[0];
                    chk("bm_00", bm_00, ham(s, 2'b00));
                    chk("bm_01", bm_01, ham(s, 2'b01));
                    chk("bm_10", bm_10, ham(s, 2'b10));
                    chk("bm_11", bm_11, ham(s, 2'b11));
                    chk("bm_sof", bm_sof, (out_idx % FL) == 0);
                    chk("bm_eof", bm_eof, (out_idx % FL) == FL - 1);
                end
            end
            if (chk_alt) chk("valid_alternates", bm_valid && prev_valid, 0);
        end
        if (!rst_n) chk("in_ready_in_reset", in_ready, 0);
        if (rst_n && !in_ready) saw_full = 1'b1;
        prev_valid = bm_valid;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n        = 0;
        in_valid = 1'b0;
        bm_ready = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, exp_q.size(), 0);
        repeat (3) cycle();
    endtask

    task automatic push_one(input logic [1:0] sym, input string tag);
        int n;
        n        = 0;
        rx_pair  = sym;
        in_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!last_push && n < 20);
        chk(tag, last_push, 1);
    endtask

    initial begin
        int         n;
        int         hs0;
        int         pushes;
        logic [1:0] stream [6];

        stream = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};

        // Reset held for 3 cycles with in_valid asserted
        rst_n    = 1'b0;
        in_valid = 1'b1;
        rx_pair  = 2'b11;
        bm_ready = 1'b1;
        repeat (3) cycle();
        chk("reset_no_push", exp_q.size(), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cycle();
        chk("in_ready_after_reset", in_ready, 1);

        // Single symbol latency and metrics
        push_one(2'b01, "single_push");
        n = 0;
        while (!bm_valid && n < 10) begin
            cycle();
            n++;
        end
        chk("single_latency", n, 3);
        chk("single_bm_00", bm_00, 1);
        chk("single_bm_01", bm_01, 0);
        chk("single_bm_10", bm_10, 2);
        chk("single_bm_11", bm_11, 1);
        chk("single_sof", bm_sof, 1);
        chk("single_eof", bm_eof, 0);
        drain("single_drain", 10);

        // Continuous stream: one result every other cycle, FIFO fills up
        saw_full   = 1'b0;
        chk_alt    = 1'b1;
        prev_valid = 1'b0;
        for (int i = 0; i < 6; i++) push_one(stream[i], "stream_push");
        drain("stream_drain", 50);
        chk_alt = 1'b0;
        chk("stream_fifo_full", saw_full, 1);

        // Backpressure: stall in PH1 with a full FIFO, then release
        hs0      = hs_cnt;
        bm_ready = 1'b0;
        in_valid = 1'b1;
        repeat (12) begin
            rx_pair = 2'($urandom);
            cycle();
        end
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", bm_valid, 1);
        chk("bp_held", exp_q.size(), 5);
        if (exp_q.size() > 1) chk("bp_ph1_operand", bmc_rx_pair, exp_q[1] ^ 2'b01);
        drain("bp_drain", 40);
        chk("bp_drain_count", hs_cnt - hs0, 5);

        // Frame markers over 10 symbols with FRAME_LEN=4
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) cycle();
        rst_n   = 1'b1;
        cycle();
        hs0     = hs_cnt;
        sof_cnt = 0;
        eof_cnt = 0;
        pushes  = 0;
        n       = 0;
        while (pushes < 10 && n < 200) begin
            in_valid = 1'b1;
            rx_pair  = 2'($urandom);
            bm_ready = 1'($urandom_range(0, 1));
            cycle();
            if (last_push) pushes++;
            n++;
        end
        chk("frame_pushes", pushes, 10);
        drain("frame_drain", 60);
        chk("frame_count", hs_cnt - hs0, 10);
        chk("frame_sof_count", sof_cnt, 3);
        chk("frame_eof_count", eof_cnt, 2);

        // Reset while stalled in PH1 with symbols buffered
        bm_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(2'($urandom), "midrst_push");
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("midrst_valid", bm_valid, 1);
        chk("midrst_inflight", exp_q.size(), 4);
        rst_n = 1'b0;
        cycle();
        chk("midrst_valid_cleared", bm_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        rst_n    = 1'b1;
        bm_ready = 1'b1;
        cycle();
        push_one(2'b10, "post_rst_push");
        in_valid = 1'b0;
        n = 0;
        while (!bm_valid && n < 10) begin
            cycle();
            n++;
        end
        chk("post_rst_valid", bm_valid, 1);
        chk("post_rst_sof", bm_sof, 1);
        chk("post_rst_bm_00", bm_00, 1);
        chk("post_rst_bm_10", bm_10, 0);
        drain("post_rst_drain", 10);

        // Randomised traffic
        repeat (400) begin
            in_valid = 1'($urandom_range(0, 1));
            rx_pair  = 2'($urandom);
            bm_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("random_drain", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bmc_seq.md
# bmc_seq

Two-phase sequencer that shares a single 2-bit-metric branch-metric unit (the hard-decision BMC that returns Hamming distances to codewords 00 and 11) across all four rate-1/2 codeword hypotheses. It sits between the received-symbol stream and the ACS array. It buffers incoming symbol pairs and drives the shared BMC twice per symbol: once with the raw pair, once with the pair XOR 2'b01. It then presents all four branch metrics to the ACS with frame markers under a valid/ready handshake.

## Interface
- FRAME_LEN, 16: symbols per traceback frame; legal range ≥2.
- FIFO_DEPTH, 4: input symbol buffer entries; power of two, ≥2.

- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  rx_pair valid
- in_ready  output  1  buffer can accept; 0 while rst_n low
- rx_pair  input  2  received hard-decision pair
- bmc_rx_pair  output  2  operand driven to the shared BMC
- bmc_path_0  input  2  BMC distance of bmc_rx_pair to 00
- bmc_path_1  input  2  BMC distance of bmc_rx_pair to 11
- bm_valid  output  1  branch metrics valid
- bm_ready  input  1  ACS accepts metrics
- bm_00, bm_01, bm_10, bm_11  output  2 each  distance of the symbol to each codeword (0..2)
- bm_sof  output  1  symbol is first of frame
- bm_eof  output  1  symbol is last of frame

## Operation
- Input handshake: a push occurs on in_valid & in_ready. in_ready = !fifo_full.
- FSM states are IDLE, PH0 and PH1.
  - IDLE → PH0 when the FIFO is non-empty.
  - PH0 → PH1 unconditionally.
  - PH1 → stays in PH1 while the output register is full and bm_ready=0 (stall).
  - PH1 → on load, goes to PH0 if the FIFO holds another entry after this pop (count−1+push ≥1), else to IDLE.
- bmc_rx_pair is combinational from the state and the FIFO head:
  - PH0: head ^ 2'b00.
  - PH1: head ^ 2'b01.
  - IDLE: 2'b00.
- PH0 captures bmc_path_0 into a temp bm_00 and bmc_path_1 into a temp bm_11.
- PH1 load: the output register takes bm_00/bm_11 from the temps, bm_01 ← bmc_path_0 and bm_10 ← bmc_path_1. bm_valid is set, the frame markers are set, and the FIFO head is popped in the same cycle.
- Load is permitted when !bm_valid or bm_ready in the same cycle (bubble-free).
- bm_valid clears on bm_ready when no load occurs. Output fields are held stable while bm_valid & !bm_ready.
- Frame counter is $clog2(FRAME_LEN) bits and advances on each load.
  - bm_sof = (count==0) and bm_eof = (count==FRAME_LEN−1), captured at load.
  - Counter wraps to 0 after FRAME_LEN−1.
- Simultaneous push and pop on a full FIFO is not allowed, since in_ready=0. On a non-full FIFO it leaves the count unchanged.
- Reset (any cycle, including mid-PH1 or mid-stall) has the following effect:
  - State → IDLE; FIFO emptied; frame counter → 0.
  - bm_valid, bm_sof, bm_eof → 0; all bm_* → 2'b00; temps → 0.
  - bmc_rx_pair → 2'b00; in_ready = 0 during reset.
  - Symbols in flight are discarded.

## Timing
- Latency: a symbol pushed at edge k into an empty, idle block gives bm_valid high after edge k+3.
- Throughput is one symbol per 2 cycles when bm_ready is held high.
- BMC is combinational: the bmc_path_* values are sampled in the same cycle that bmc_rx_pair is driven.
- in_ready rises in the first cycle after rst_n returns high.

## Structure
- Package viterbi_pkg holds:
  - typedef metric_t (logic [1:0]);
  - enum seq_state_t {IDLE, PH0, PH1};
  - constants PH0_MASK=2'b00 and PH1_MASK=2'b01.
- Sub-module sym_fifo: a parameterised 2-bit synchronous FIFO with push/pop/full/empty/count.
- The BMC instance is external and shared. It is connected at the top level through the bmc_* ports.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → in_ready=0, bm_valid=0, all metrics 0, bmc_rx_pair=00; no push is recorded.
- Single symbol rx_pair=2'b01, bm_ready=1 → bm_valid after edge k+3 with bm_00=1, bm_01=0, bm_10=2, bm_11=1, bm_sof=1, bm_eof=0.
- Stream of 00, 11, 10, 01, 00, 11 with in_valid=1 and bm_ready=1:
  - metrics {00:0,01:1,10:1,11:2} then {2,1,1,0} then {1,2,0,1} then {1,0,2,1} then the first two repeat;
  - bm_valid is high every second cycle;
  - in_ready drops once the FIFO reaches 4.
- Backpressure: bm_ready=0 for 12 cycles while feeding → outputs stable, FSM stalls in PH1, FIFO full, in_ready=0. Releasing bm_ready drains all symbols in order, one per 2 cycles.
- Frames with FRAME_LEN=4 and 10 symbols → bm_sof on symbols 0, 4, 8; bm_eof on symbols 3, 7; counter wraps cleanly.
- Reset asserted while in PH1 with bm_valid=1 and 3 symbols buffered → all outputs return to reset values next edge. A new symbol afterwards yields bm_sof=1 with correct metrics.
